// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding, frame constants, parity helper.
// No logic of its own; imported by the transmitter and its FIFO.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } uart_state_e;

    localparam int   UART_DATA_BITS = 8;
    localparam logic UART_IDLE      = 1'b1;

    function automatic logic even_parity(input logic [UART_DATA_BITS-1:0] d);
        return ^d;
    endfunction

endpackage

// File: rtl/uart_fifo.sv
// DEPTH x 8 synchronous FIFO, first-word-fall-through dout.
// Latency: written byte visible on dout the cycle after the write.
// Backpressure: write while full is accepted only alongside a pop; otherwise ignored.
module uart_fifo
    import uart_pkg::*;
#(
    parameter int DEPTH = 16
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      wr,
    input  logic                      rd,
    input  logic [UART_DATA_BITS-1:0] din,
    output logic [UART_DATA_BITS-1:0] dout,
    output logic                      empty,
    output logic                      full
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [UART_DATA_BITS-1:0] mem [DEPTH];
    logic [AW-1:0]             wr_ptr;
    logic [AW-1:0]             rd_ptr;
    logic [CW-1:0]             count;
    logic [CW-1:0]             count_nxt;
    logic                      full_q;
    logic                      wr_acc;
    logic                      rd_acc;

    // A pop frees the slot the same cycle, so a full FIFO can still take a write.
    assign rd_acc    = rd & (count != '0);
    assign wr_acc    = wr & (~full_q | rd_acc);
    assign count_nxt = count + CW'(wr_acc) - CW'(rd_acc);

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            full_q <= 1'b0;
        end else begin
            if (wr_acc) wr_ptr <= wr_ptr + AW'(1);
            if (rd_acc) rd_ptr <= rd_ptr + AW'(1);
            count  <= count_nxt;
            full_q <= (count_nxt == CW'(DEPTH));
        end
    end

    always_ff @(posedge clk) begin
        if (wr_acc) mem[wr_ptr] <= din;
    end

    assign dout  = mem[rd_ptr];
    assign empty = (count == '0);
    assign full  = full_q;

endmodule

// File: rtl/uart_tx_buf.sv
// Buffered UART transmitter, one bit per clk; optional even parity with UART_TX_PARITY_EN.
// Latency: start bit on out one edge after the strobe edge when idle; frames run back-to-back.
// Backpressure: none upstream; writes into a full FIFO without a pop are dropped and set ovf.
module uart_tx_buf
    import uart_pkg::*;
#(
    parameter int DEPTH     = 16,
    parameter int STOP_BITS = 1
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [UART_DATA_BITS-1:0] in,
    input  logic                      clk_in,
    output logic                      out,
    output logic                      busy,
    output logic                      full,
    output logic                      ovf
);

    localparam int BW = $clog2(UART_DATA_BITS);
    localparam logic [BW-1:0] LAST_BIT  = BW'(UART_DATA_BITS - 1);
    localparam logic          LAST_STOP = 1'(STOP_BITS - 1);

    uart_state_e               state_q, state_d;
    logic [UART_DATA_BITS-1:0] shift_q, shift_d;
    logic [BW-1:0]             bit_cnt_q, bit_cnt_d;
    logic                      stop_cnt_q, stop_cnt_d;
    logic                      out_q, out_d;
    logic                      clk_in_q;
    logic                      ovf_q;
    logic                      wr;
    logic                      load;
    logic                      fifo_empty;
    logic                      fifo_full;
    logic [UART_DATA_BITS-1:0] fifo_dout;
`ifdef UART_TX_PARITY_EN
    logic                      par_q, par_d;
`endif

    assign wr = clk_in & ~clk_in_q;

    uart_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .wr    (wr),
        .rd    (load),
        .din   (in),
        .dout  (fifo_dout),
        .empty (fifo_empty),
        .full  (fifo_full)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            shift_q    <= '0;
            bit_cnt_q  <= '0;
            stop_cnt_q <= 1'b0;
            out_q      <= UART_IDLE;
            clk_in_q   <= 1'b0;
            ovf_q      <= 1'b0;
`ifdef UART_TX_PARITY_EN
            par_q      <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            shift_q    <= shift_d;
            bit_cnt_q  <= bit_cnt_d;
            stop_cnt_q <= stop_cnt_d;
            out_q      <= out_d;
            clk_in_q   <= clk_in;
            ovf_q      <= ovf_q | (wr & fifo_full & ~load);
`ifdef UART_TX_PARITY_EN
            par_q      <= par_d;
`endif
        end
    end

    always_comb begin
        state_d    = state_q;
        shift_d    = shift_q;
        bit_cnt_d  = bit_cnt_q;
        stop_cnt_d = stop_cnt_q;
        out_d      = out_q;
        load       = 1'b0;
`ifdef UART_TX_PARITY_EN
        par_d      = par_q;
`endif
        case (state_q)
            IDLE: begin
                out_d = UART_IDLE;
                load  = ~fifo_empty;
            end
            START: begin
                out_d     = shift_q[0];
                shift_d   = shift_q >> 1;
                bit_cnt_d = '0;
                state_d   = DATA;
            end
            DATA: begin
                if (bit_cnt_q == LAST_BIT) begin
`ifdef UART_TX_PARITY_EN
                    out_d   = par_q;
                    state_d = PARITY;
`else
                    out_d      = UART_IDLE;
                    stop_cnt_d = 1'b0;
                    state_d    = STOP;
`endif
                end else begin
                    out_d     = shift_q[0];
                    shift_d   = shift_q >> 1;
                    bit_cnt_d = bit_cnt_q + BW'(1);
                end
            end
`ifdef UART_TX_PARITY_EN
            PARITY: begin
                out_d      = UART_IDLE;
                stop_cnt_d = 1'b0;
                state_d    = STOP;
            end
`endif
            STOP: begin
                if (stop_cnt_q == LAST_STOP) begin
                    load    = ~fifo_empty;
                    state_d = IDLE;
                end else begin
                    stop_cnt_d = stop_cnt_q + 1'b1;
                end
            end
            default: begin
                out_d   = UART_IDLE;
                state_d = IDLE;
            end
        endcase
        // Pop and start bit share one edge, giving back-to-back frames out of STOP.
        if (load) begin
            shift_d = fifo_dout;
            out_d   = ~UART_IDLE;
            state_d = START;
`ifdef UART_TX_PARITY_EN
            par_d   = even_parity(fifo_dout);
`endif
        end
    end

    assign out  = out_q;
    assign busy = (state_q != IDLE);
    assign full = fifo_full;
    assign ovf  = ovf_q;

endmodule

// File: tb/tb_uart_tx_buf.sv
// Directed bench for uart_tx_buf: bit timing, back-to-back frames, strobe edge
// detection, full/overflow and mid-frame reset, with a serial line decoder.
module tb_uart_tx_buf;

`ifdef UART_TX_PARITY_EN
    localparam int FRAME_LEN = 11;
`else
    localparam int FRAME_LEN = 10;
`endif

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] in_r;
    logic       clk_in_r;
    logic       out;
    logic       busy;
    logic       full;
    logic       ovf;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    typedef struct {
        logic [7:0] data;
        int         start;
        bit         err;
    } frame_t;

    frame_t     fq[$];
    bit         mon_active = 1'b0;
    int         mon_idx;
    int         mon_start;
    logic [7:0] mon_data;
    bit         mon_err;

    uart_tx_buf #(.DEPTH(16), .STOP_BITS(1)) dut (
        .clk    (clk),
        .rst    (rst),
        .in     (in_r),
        .clk_in (clk_in_r),
        .out    (out),
        .busy   (busy),
        .full   (full),
        .ovf    (ovf)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Line decoder: LSB-first data, optional even parity, one stop bit.
    always @(negedge clk) begin
        if (rst) begin
            mon_active = 1'b0;
        end else if (!mon_active) begin
            if (out === 1'b0) begin
                mon_active = 1'b1;
                mon_idx    = 0;
                mon_start  = cyc;
                mon_data   = 8'h00;
                mon_err    = 1'b0;
            end
        end else begin
            if (mon_idx < 8) begin
                mon_data = {out, mon_data[7:1]};
            end
`ifdef UART_TX_PARITY_EN
            else if (mon_idx == 8) begin
                if (out !== ^mon_data) mon_err = 1'b1;
            end
`endif
            else begin
                if (out !== 1'b1) mon_err = 1'b1;
                fq.push_back('{mon_data, mon_start, mon_err});
                mon_active = 1'b0;
            end
            mon_idx++;
        end
    end

    task automatic test_reset();
        rst = 1'b1; in_r = 8'h00; clk_in_r = 1'b0;
        repeat (3) @(negedge clk);
        total++; if (out !== 1'b1)  begin bad++; $display("FAIL reset_out got=%b want=1", out); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b want=0", busy); end
        total++; if (full !== 1'b0) begin bad++; $display("FAIL reset_full got=%b want=0", full); end
        total++; if (ovf !== 1'b0)  begin bad++; $display("FAIL reset_ovf got=%b want=0", ovf); end
        rst = 1'b0;
        repeat (3) @(negedge clk);
        total++; if (out !== 1'b1 || busy !== 1'b0) begin
            bad++; $display("FAIL post_reset_idle out=%b busy=%b want out=1 busy=0", out, busy);
        end
    endtask

    task automatic test_single();
        int         base = fq.size();
        logic [9:0] exp  = {1'b1, 8'hA5, 1'b0};
        in_r = 8'hA5; clk_in_r = 1'b1;
        @(negedge clk);
        clk_in_r = 1'b0;
        for (int k = 1; k <= 10; k++) begin
            @(negedge clk);
            total++; if (out !== exp[k-1]) begin
                bad++; $display("FAIL single_bit e+%0d got=%b want=%b", k, out, exp[k-1]);
            end
            total++; if (busy !== 1'b1) begin
                bad++; $display("FAIL single_busy e+%0d got=%b want=1", k, busy);
            end
        end
        @(negedge clk);
        total++; if (busy !== 1'b0 || out !== 1'b1) begin
            bad++; $display("FAIL single_end busy=%b out=%b want busy=0 out=1", busy, out);
        end
        total++; if (fq.size() != base + 1) begin
            bad++; $display("FAIL single_frames got=%0d want=1", fq.size() - base);
        end else if (fq[base].data !== 8'hA5 || fq[base].err) begin
            bad++; $display("FAIL single_data got=%h err=%b want=a5 err=0", fq[base].data, fq[base].err);
        end
    endtask

    task automatic test_back_to_back();
        int         base = fq.size();
        logic [7:0] v [3] = '{8'h00, 8'hFF, 8'h3C};
        for (int i = 0; i < 3; i++) begin
            in_r = v[i]; clk_in_r = 1'b1;
            @(negedge clk);
            clk_in_r = 1'b0;
            @(negedge clk);
        end
        for (int c = 0; c < 80 && fq.size() < base + 3; c++) @(negedge clk);
        total++;
        if (fq.size() < base + 3) begin
            bad++; $display("FAIL b2b_timeout got=%0d frames want=3", fq.size() - base);
        end else begin
            for (int i = 0; i < 3; i++) begin
                total++; if (fq[base+i].data !== v[i] || fq[base+i].err) begin
                    bad++; $display("FAIL b2b_data[%0d] got=%h err=%b want=%h", i, fq[base+i].data, fq[base+i].err, v[i]);
                end
                if (i > 0) begin
                    total++; if (fq[base+i].start - fq[base+i-1].start != FRAME_LEN) begin
                        bad++; $display("FAIL b2b_gap[%0d] got=%0d want=%0d", i, fq[base+i].start - fq[base+i-1].start, FRAME_LEN);
                    end
                end
            end
        end
        for (int c = 0; c < 20 && busy; c++) @(negedge clk);
        @(negedge clk);
    endtask

    task automatic test_hold_strobe();
        int base = fq.size();
        in_r = 8'hC3; clk_in_r = 1'b1;
        for (int c = 0; c < 50; c++) begin
            @(negedge clk);
            if (c == 10) in_r = 8'h11;
        end
        clk_in_r = 1'b0;
        repeat (30) @(negedge clk);
        total++; if (fq.size() != base + 1) begin
            bad++; $display("FAIL hold_frames got=%0d want=1", fq.size() - base);
        end else if (fq[base].data !== 8'hC3) begin
            bad++; $display("FAIL hold_data got=%h want=c3", fq[base].data);
        end
    endtask

    // Strobes every 2 cycles against a pop every 10: write 19 fills, write 20 is dropped.
    task automatic test_full_ovf();
        int base = fq.size();
        for (int i = 0; i <= 20; i++) begin
            in_r = 8'h10 + 8'(i); clk_in_r = 1'b1;
            @(negedge clk);
            if (i == 18) begin
                total++; if (full !== 1'b0 || ovf !== 1'b0) begin
                    bad++; $display("FAIL fill_w18 full=%b ovf=%b want 0 0", full, ovf);
                end
            end
            if (i == 19) begin
                total++; if (full !== 1'b1) begin bad++; $display("FAIL fill_w19_full got=%b want=1", full); end
                total++; if (ovf !== 1'b0)  begin bad++; $display("FAIL fill_w19_ovf got=%b want=0", ovf); end
            end
            if (i == 20) begin
                total++; if (ovf !== 1'b1)  begin bad++; $display("FAIL drop_ovf got=%b want=1", ovf); end
                total++; if (full !== 1'b1) begin bad++; $display("FAIL drop_full got=%b want=1", full); end
            end
            clk_in_r = 1'b0;
            @(negedge clk);
            if (i == 20) begin
                total++; if (full !== 1'b0 || ovf !== 1'b1) begin
                    bad++; $display("FAIL after_pop full=%b ovf=%b want 0 1", full, ovf);
                end
            end
        end
        for (int c = 0; c < 400 && fq.size() < base + 20; c++) @(negedge clk);
        repeat (30) @(negedge clk);
        total++;
        if (fq.size() != base + 20) begin
            bad++; $display("FAIL fill_frames got=%0d want=20", fq.size() - base);
        end else begin
            for (int i = 0; i < 20; i++) begin
                total++; if (fq[base+i].data !== 8'h10 + 8'(i) || fq[base+i].err) begin
                    bad++; $display("FAIL fill_data[%0d] got=%h want=%h", i, fq[base+i].data, 8'h10 + 8'(i));
                end
            end
        end
    endtask

    task automatic test_reset_mid();
        int base = fq.size();
        bit went_low = 1'b0;
        in_r = 8'h4A; clk_in_r = 1'b1;
        @(negedge clk);
        clk_in_r = 1'b0;
        @(negedge clk);
        in_r = 8'h6B; clk_in_r = 1'b1;
        @(negedge clk);
        clk_in_r = 1'b0;
        repeat (4) @(negedge clk);
        total++; if (out !== 1'b0 || busy !== 1'b1) begin
            bad++; $display("FAIL mid_bit4 out=%b busy=%b want out=0 busy=1", out, busy);
        end
        rst = 1'b1;
        @(negedge clk);
        total++; if (out !== 1'b1)  begin bad++; $display("FAIL mid_rst_out got=%b want=1", out); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL mid_rst_busy got=%b want=0", busy); end
        total++; if (full !== 1'b0 || ovf !== 1'b0) begin
            bad++; $display("FAIL mid_rst_flags full=%b ovf=%b want 0 0", full, ovf);
        end
        rst = 1'b0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (out !== 1'b1) went_low = 1'b1;
        end
        total++; if (went_low || fq.size() != base) begin
            bad++; $display("FAIL mid_quiet went_low=%b frames=%0d want 0 0", went_low, fq.size() - base);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_hold_strobe();
        test_full_ovf();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
